// File: rtl/circle_pkg.sv
// Shared types and constants for the parametrised midpoint-circle rasteriser.
package circle_pkg;

    typedef enum logic [2:0] {
        READY = 3'd0,
        PREP  = 3'd1,
        PLOT  = 3'd2,
        CALC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef logic [2:0] octant_t;
    typedef logic [1:0] span_t;

    localparam logic MODE_OUTLINE = 1'b0;
    localparam logic MODE_FILL    = 1'b1;

    // Signed coordinate width: widest operand plus carry and sign bits
    function automatic int coord_width(input int xw, input int yw, input int rw);
        int m;
        m = (xw > yw) ? xw : yw;
        m = (rw > m) ? rw : m;
        return m + 2;
    endfunction

endpackage

// File: rtl/circle_raster_p_if.sv
// Draw request / pixel output bundle between a requester and the rasteriser.
interface circle_raster_p_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic                fill;
    logic [COLOUR_W-1:0] colour;
    logic [X_W-1:0]      centre_x;
    logic [Y_W-1:0]      centre_y;
    logic [R_W-1:0]      radius;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        output start, fill, colour, centre_x, centre_y, radius,
        input  done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, fill, colour, centre_x, centre_y, radius,
        output done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/circle_clip.sv
// Screen-bounds test for a signed candidate pixel; passes the low coordinate bits through.
module circle_clip #(
    parameter int CW       = 10,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic signed [CW-1:0] x,
    input  logic signed [CW-1:0] y,
    output logic                 in_bounds,
    output logic [X_W-1:0]       tx,
    output logic [Y_W-1:0]       ty
);
    localparam logic signed [CW-1:0] LIM_X = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] LIM_Y = CW'(SCREEN_H);

    assign in_bounds = !x[CW-1] && (x < LIM_X) && !y[CW-1] && (y < LIM_Y);
    assign tx        = x[X_W-1:0];
    assign ty        = y[Y_W-1:0];
endmodule

// File: rtl/circle_raster_p.sv
// Midpoint-circle rasteriser: outline (8 octants) or filled disc (4 spans), one candidate pixel per cycle.
module circle_raster_p
    import circle_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input logic              clk,
    input logic              rst_n,
    circle_raster_p_if.slave bus
);
    localparam int CW = coord_width(X_W, Y_W, R_W);
    localparam int KW = R_W + 3;
    localparam logic signed [CW-1:0] C_ZERO   = {CW{1'b0}};
    localparam logic signed [CW-1:0] C_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic signed [KW-1:0] CRIT_ONE = {{(KW-1){1'b0}}, 1'b1};

    state_t               state_r, state_s;
    logic                 fill_r;
    logic [COLOUR_W-1:0]  colour_r;
    logic [R_W-1:0]       rad_r;
    logic signed [CW-1:0] cx_r, cy_r, ox_r, oy_r, pos_r;
    logic signed [KW-1:0] crit_r, crit_s;
    octant_t              oct_r;
    span_t                span_r;
    logic signed [CW-1:0] ext_s, ox_s, oy_s, cand_x_s, cand_y_s;
    logic                 span_end_s, plot_last_s, in_bounds_s, crit_le0_s;
    logic [X_W-1:0]       clip_x_s;
    logic [Y_W-1:0]       clip_y_s;

    // Candidate pixel for the current octant or span position
    always_comb begin
        ext_s       = span_r[1] ? oy_r : ox_r;
        span_end_s  = (pos_r == (ext_s <<< 1));
        cand_x_s    = cx_r;
        cand_y_s    = cy_r;
        plot_last_s = 1'b0;
        if (fill_r == MODE_FILL) begin
            cand_x_s = cx_r - ext_s + pos_r;
            case (span_r)
                2'd0:    cand_y_s = cy_r + oy_r;
                2'd1:    cand_y_s = cy_r - oy_r;
                2'd2:    cand_y_s = cy_r + ox_r;
                2'd3:    cand_y_s = cy_r - ox_r;
                default: cand_y_s = cy_r;
            endcase
            plot_last_s = span_end_s && (span_r == 2'd3);
        end else begin
            case (oct_r)
                3'd0:    begin cand_x_s = cx_r + ox_r; cand_y_s = cy_r + oy_r; end
                3'd1:    begin cand_x_s = cx_r + oy_r; cand_y_s = cy_r + ox_r; end
                3'd2:    begin cand_x_s = cx_r - ox_r; cand_y_s = cy_r + oy_r; end
                3'd3:    begin cand_x_s = cx_r - oy_r; cand_y_s = cy_r + ox_r; end
                3'd4:    begin cand_x_s = cx_r - ox_r; cand_y_s = cy_r - oy_r; end
                3'd5:    begin cand_x_s = cx_r - oy_r; cand_y_s = cy_r - ox_r; end
                3'd6:    begin cand_x_s = cx_r + ox_r; cand_y_s = cy_r - oy_r; end
                3'd7:    begin cand_x_s = cx_r + oy_r; cand_y_s = cy_r - ox_r; end
                default: begin cand_x_s = cx_r;        cand_y_s = cy_r;        end
            endcase
            plot_last_s = (oct_r == 3'd7);
        end
    end

    // Midpoint step; the decrement of ox happens before it feeds the criterion update
    always_comb begin
        oy_s       = oy_r + C_ONE;
        crit_le0_s = crit_r[KW-1] || (crit_r == {KW{1'b0}});
        if (crit_le0_s) begin
            ox_s   = ox_r;
            crit_s = crit_r + KW'(oy_s <<< 1) + CRIT_ONE;
        end else begin
            ox_s   = ox_r - C_ONE;
            crit_s = crit_r + KW'((oy_s - ox_s) <<< 1) + CRIT_ONE;
        end
    end

    circle_clip #(
        .CW(CW), .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) u_clip (
        .x(cand_x_s), .y(cand_y_s), .in_bounds(in_bounds_s), .tx(clip_x_s), .ty(clip_y_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= READY;
        else        state_r <= state_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            READY:   state_s = bus.start ? PREP : READY;
            PREP:    state_s = PLOT;
            PLOT:    state_s = plot_last_s ? CALC : PLOT;
            CALC:    state_s = (oy_s <= ox_s) ? PLOT : DONE;
            DONE:    state_s = bus.start ? DONE : READY;
            default: state_s = READY;
        endcase
    end

    // Output logic
    always_comb begin
        bus.done       = (state_r == DONE);
        bus.vga_plot   = (state_r == PLOT) && in_bounds_s;
        bus.vga_x      = clip_x_s;
        bus.vga_y      = clip_y_s;
        bus.vga_colour = colour_r;
    end

    // Request latch, offsets, criterion and octant/span walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_r   <= 1'b0;
            colour_r <= {COLOUR_W{1'b0}};
            rad_r    <= {R_W{1'b0}};
            cx_r     <= C_ZERO;
            cy_r     <= C_ZERO;
            ox_r     <= C_ZERO;
            oy_r     <= C_ZERO;
            pos_r    <= C_ZERO;
            crit_r   <= {KW{1'b0}};
            oct_r    <= 3'd0;
            span_r   <= 2'd0;
        end else begin
            case (state_r)
                READY: begin
                    if (bus.start) begin
                        fill_r   <= bus.fill;
                        colour_r <= bus.colour;
                        rad_r    <= bus.radius;
                        cx_r     <= $signed({{(CW-X_W){1'b0}}, bus.centre_x});
                        cy_r     <= $signed({{(CW-Y_W){1'b0}}, bus.centre_y});
                    end
                end
                PREP: begin
                    ox_r   <= $signed({{(CW-R_W){1'b0}}, rad_r});
                    oy_r   <= C_ZERO;
                    crit_r <= CRIT_ONE - $signed({3'b000, rad_r});
                    pos_r  <= C_ZERO;
                    oct_r  <= 3'd0;
                    span_r <= 2'd0;
                end
                PLOT: begin
                    if (fill_r == MODE_FILL) begin
                        if (span_end_s) begin
                            pos_r  <= C_ZERO;
                            span_r <= span_r + 2'd1;
                        end else begin
                            pos_r  <= pos_r + C_ONE;
                        end
                    end else begin
                        oct_r <= oct_r + 3'd1;
                    end
                end
                CALC: begin
                    ox_r   <= ox_s;
                    oy_r   <= oy_s;
                    crit_r <= crit_s;
                    pos_r  <= C_ZERO;
                    oct_r  <= 3'd0;
                    span_r <= 2'd0;
                end
                default: begin
                    oct_r <= oct_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_circle_raster_p.sv
// Directed and randomised checks of circle_raster_p against an integer midpoint-circle model.
module tb_circle_raster_p;
    import circle_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    circle_raster_p_if bus ();
    circle_raster_p_if #(.X_W(9), .Y_W(8), .R_W(9), .COLOUR_W(3)) bus6 ();

    circle_raster_p dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    circle_raster_p #(
        .X_W(9), .Y_W(8), .R_W(9), .COLOUR_W(3), .SCREEN_W(320), .SCREEN_H(240)
    ) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

    typedef struct packed { int x; int y; } pix_t;
    pix_t exp_q[$];
    pix_t got_q[$];
    int checks = 0;
    int failures = 0;
    int exp_cycles, exp_iters, got_cycles, colour_bad;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic emit(input int x, input int y, input int sw, input int sh);
        exp_cycles++;
        if (x >= 0 && x < sw && y >= 0 && y < sh) exp_q.push_back('{x: x, y: y});
    endtask

    // Reference: candidate list and cycle count (PREP + candidates + CALCs) in plain integers
    task automatic model(input bit f, input int cx, input int cy, input int r, input int sw, input int sh);
        int ox, oy, crit;
        int row[4], ext[4], dx[8], dy[8];
        exp_q.delete();
        exp_cycles = 1;
        exp_iters  = 0;
        ox = r; oy = 0; crit = 1 - r;
        do begin
            if (f) begin
                row = '{cy + oy, cy - oy, cy + ox, cy - ox};
                ext = '{ox, ox, oy, oy};
                for (int s = 0; s < 4; s++)
                    for (int x = cx - ext[s]; x <= cx + ext[s]; x++) emit(x, row[s], sw, sh);
            end else begin
                dx = '{ox, oy, -ox, -oy, -ox, -oy, ox, oy};
                dy = '{oy, ox, oy, ox, -oy, -ox, -oy, -ox};
                for (int k = 0; k < 8; k++) emit(cx + dx[k], cy + dy[k], sw, sh);
            end
            exp_iters++;
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin ox--; crit += 2 * (oy - ox) + 1; end
            exp_cycles++;
        end while (oy <= ox);
    endtask

    task automatic compare_pixels(input string tag);
        int bad = 0;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check({tag, "_pixels"}, bad, 0);
    endtask

    function automatic int has_pixel(input int x, input int y);
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i].x == x && got_q[i].y == y) return 1;
        return 0;
    endfunction

    task automatic run_draw(input bit f, input int col, input int cx, input int cy, input int r);
        int cyc = 0;
        got_q.delete();
        colour_bad = 0;
        @(negedge clk);
        bus.fill = f; bus.colour = 3'(col); bus.centre_x = 8'(cx);
        bus.centre_y = 7'(cy); bus.radius = 8'(r); bus.start = 1'b1;
        @(negedge clk);
        check("state_prep", int'(dut.state_r), int'(PREP));
        while (bus.done !== 1'b1 && cyc < 20000) begin
            if (bus.vga_plot === 1'b1) begin
                got_q.push_back('{x: int'(bus.vga_x), y: int'(bus.vga_y)});
                if (bus.vga_colour !== 3'(col)) colour_bad++;
            end
            cyc++;
            @(negedge clk);
        end
        got_cycles = cyc;
        check("done_rise", int'(bus.done), 1);
    endtask

    task automatic release_start();
        bus.start = 1'b0;
        @(negedge clk);
        check("done_fall", int'(bus.done), 0);
        check("state_ready", int'(dut.state_r), int'(READY));
    endtask

    initial begin
        int f, cx, cy, r, c, bad, s1_cycles, cyc, oob;
        int seen[int];
        rst_n = 1'b0;
        bus.start = 1'b0; bus.fill = 1'b0; bus.colour = 3'd0;
        bus.centre_x = 8'd0; bus.centre_y = 7'd0; bus.radius = 8'd0;
        bus6.start = 1'b0; bus6.fill = 1'b0; bus6.colour = 3'd0;
        bus6.centre_x = 9'd0; bus6.centre_y = 8'd0; bus6.radius = 9'd0;
        #12;
        check("rst_done", int'(bus.done), 0);
        check("rst_plot", int'(bus.vga_plot), 0);
        check("rst_x", int'(bus.vga_x), 0);
        check("rst_y", int'(bus.vga_y), 0);
        check("rst_colour", int'(bus.vga_colour), 0);
        check("rst_state", int'(dut.state_r), int'(READY));
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: centred outline
        model(1'b0, 80, 60, 10, 160, 120);
        run_draw(1'b0, 4, 80, 60, 10);
        compare_pixels("s1");
        check("s1_count64", got_q.size(), 64);
        check("s1_cycles", got_cycles, exp_cycles);
        check("s1_latency", got_cycles, 1 + 9 * exp_iters);
        check("s1_colour", colour_bad, 0);
        check("s1_p90_60", has_pixel(90, 60), 1);
        check("s1_p80_70", has_pixel(80, 70), 1);
        check("s1_p73_53", has_pixel(73, 53), 1);
        check("s1_p87_67", has_pixel(87, 67), 1);
        s1_cycles = got_cycles;

        // Scenario 2: done held while start stays high, then re-arm
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done !== 1'b1 || bus.vga_plot !== 1'b0) bad++;
        end
        check("s2_done_hold", bad, 0);
        release_start();
        for (int t = 0; t < 4; t++) begin
            f  = int'($urandom_range(0, 1));
            cx = int'($urandom_range(0, 159));
            cy = int'($urandom_range(0, 127));
            r  = int'($urandom_range(0, 30));
            c  = int'($urandom_range(0, 7));
            model(f[0], cx, cy, r, 160, 120);
            run_draw(f[0], c, cx, cy, r);
            compare_pixels("rnd");
            check("rnd_cycles", got_cycles, exp_cycles);
            check("rnd_colour", colour_bad, 0);
            release_start();
        end

        // Scenario 3: corner-clipped outline keeps the same cycle count
        model(1'b0, 0, 0, 10, 160, 120);
        run_draw(1'b0, 2, 0, 0, 10);
        compare_pixels("s3");
        check("s3_count18", got_q.size(), 18);
        check("s3_cycles", got_cycles, s1_cycles);
        oob = 0;
        foreach (got_q[i]) if (got_q[i].x >= 160 || got_q[i].y >= 120) oob++;
        check("s3_bounds", oob, 0);
        release_start();

        // Scenario 4: small filled discs
        model(1'b1, 10, 10, 1, 160, 120);
        run_draw(1'b1, 5, 10, 10, 1);
        compare_pixels("s4");
        check("s4_count20", got_q.size(), 20);
        oob = 0;
        foreach (got_q[i]) begin
            seen[got_q[i].x * 256 + got_q[i].y] = 1;
            if (got_q[i].x < 9 || got_q[i].x > 11 || got_q[i].y < 9 || got_q[i].y > 11) oob++;
        end
        check("s4_unique9", seen.num(), 9);
        check("s4_range", oob, 0);
        release_start();
        run_draw(1'b1, 5, 10, 10, 0);
        check("s4_r0_count", got_q.size(), 4);
        check("s4_r0_pixel", has_pixel(10, 10), 1);
        check("s4_r0_cycles", got_cycles, 6);
        release_start();

        // Scenario 5: asynchronous reset during PLOT
        @(negedge clk);
        bus.fill = 1'b0; bus.colour = 3'd4; bus.centre_x = 8'd80;
        bus.centre_y = 7'd60; bus.radius = 8'd10; bus.start = 1'b1;
        repeat (20) @(negedge clk);
        check("s5_in_plot", int'(dut.state_r), int'(PLOT));
        check("s5_plot_pre", int'(bus.vga_plot), 1);
        #2 rst_n = 1'b0;
        #1;
        check("s5_plot", int'(bus.vga_plot), 0);
        check("s5_done", int'(bus.done), 0);
        check("s5_x", int'(bus.vga_x), 0);
        check("s5_y", int'(bus.vga_y), 0);
        check("s5_colour", int'(bus.vga_colour), 0);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model(1'b0, 80, 60, 10, 160, 120);
        run_draw(1'b0, 6, 80, 60, 10);
        compare_pixels("s5_after");
        check("s5_cycles", got_cycles, exp_cycles);
        release_start();

        // Scenario 6: wider instance, large radius
        model(1'b0, 160, 120, 200, 320, 240);
        got_q.delete();
        oob = 0;
        cyc = 0;
        @(negedge clk);
        bus6.fill = 1'b0; bus6.colour = 3'd1; bus6.centre_x = 9'd160;
        bus6.centre_y = 8'd120; bus6.radius = 9'd200; bus6.start = 1'b1;
        @(negedge clk);
        while (bus6.done !== 1'b1 && cyc < 20000) begin
            if (bus6.vga_plot === 1'b1) begin
                got_q.push_back('{x: int'(bus6.vga_x), y: int'(bus6.vga_y)});
                if (int'(bus6.vga_x) >= 320 || int'(bus6.vga_y) >= 240) oob++;
            end
            cyc++;
            @(negedge clk);
        end
        check("s6_done", int'(bus6.done), 1);
        check("s6_bounds", oob, 0);
        check("s6_plot_cycles", cyc - 1 - exp_iters, 8 * exp_iters);
        compare_pixels("s6");
        bus6.start = 1'b0;
        @(negedge clk);
        check("s6_done_fall", int'(bus6.done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/circle_raster_p.md
Name: circle_raster_p

Overview:
Parametrised midpoint-circle rasteriser for the VGA pixel path, the successor to the fixed 160x120 outline circle block.
- Generalises coordinate, radius and colour widths and the screen size.
- Adds a filled-disc mode (horizontal spans) and per-pixel screen clipping.
- Emits one candidate pixel per cycle toward the VGA framebuffer adapter, with the same level start/done handshake.

Parameters:
X_W, 8, width of centre_x / vga_x
Y_W, 7, width of centre_y / vga_y
R_W, 8, width of radius
COLOUR_W, 3, width of colour / vga_colour
SCREEN_W, 160, visible columns; valid x is 0..SCREEN_W-1
SCREEN_H, 120, visible rows; valid y is 0..SCREEN_H-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; asynchronous, active-low
start  in  1  level request; held high until done is seen
fill  in  1  0 = outline, 1 = filled disc; latched at start
colour  in  COLOUR_W  pixel colour; latched at start
centre_x  in  X_W  centre column; latched at start
centre_y  in  Y_W  centre row; latched at start
radius  in  R_W  radius; latched at start
done  out  1  drawing finished; high in DONE
vga_x  out  X_W  pixel column
vga_y  out  Y_W  pixel row
vga_colour  out  COLOUR_W  latched colour
vga_plot  out  1  write strobe for the current pixel

Behaviour:
- Reset (async, any state including mid-draw):
  - state=READY.
  - done, vga_plot, vga_x, vga_y, vga_colour all 0.
  - Internal registers cleared.
- States: READY, PREP, PLOT, CALC, DONE.
- READY:
  - When start=1, latch all inputs and go to PREP.
  - vga_colour takes the latched colour from PREP onward.
- PREP (1 cycle, vga_plot=0):
  - offset_x=radius, offset_y=0, crit=1-radius.
  - Clear point/span counters.
  - Go to PLOT.
- PLOT, outline mode: 8 cycles, one per octant, in this order:
  - (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-ox,cy+oy), (cx-oy,cy+ox)
  - (cx-ox,cy-oy), (cx-oy,cy-ox), (cx+ox,cy-oy), (cx+oy,cy-ox)
- PLOT, fill mode: four spans, each scanned left to right, one pixel per cycle:
  - S0: row cy+oy, x from cx-ox to cx+ox.
  - S1: row cy-oy, same x range.
  - S2: row cy+ox, x from cx-oy to cx+oy.
  - S3: row cy-ox, same x range.
  - Span length is 2*extent+1.
  - Duplicate pixels are plotted, never suppressed.
- Clipping:
  - Coordinates are computed signed, width max(X_W,Y_W,R_W)+2.
  - vga_plot=1 only if 0<=x<SCREEN_W and 0<=y<SCREEN_H.
  - Off-screen candidates still consume their cycle; cycle count is independent of position.
  - vga_x/vga_y carry the truncated low bits and are don't-care when vga_plot=0.
- After the last PLOT cycle go to CALC (1 cycle, vga_plot=0):
  - offset_y += 1.
  - If crit<=0: crit += 2*offset_y+1.
  - Else: offset_x -= 1, then crit += 2*(offset_y-offset_x)+1, using the updated values.
  - crit is signed, R_W+3 bits.
  - If offset_y<=offset_x go to PLOT, else go to DONE.
- DONE:
  - done=1, vga_plot=0.
  - Hold while start=1.
  - When start=0: go to READY; done=0 from the next cycle.
- start changes in PREP, PLOT or CALC are ignored.
- radius=0:
  - Outline: 8 plots of (cx,cy).
  - Fill: 4 plots of (cx,cy).
  - In both cases one CALC, then DONE.
- Outline total latency: 1 + iterations*9 cycles from PREP to entering DONE.

Decomposition:
- Package circle_pkg holds:
  - State enum (READY, PREP, PLOT, CALC, DONE).
  - Octant index 0..7 and span index 0..3 typedefs.
  - Mode constants MODE_OUTLINE=0, MODE_FILL=1.
- One combinational sub-module, circle_clip: signed x/y in, SCREEN_W/SCREEN_H params, outputs in_bounds plus truncated x/y.
- Everything else lives in circle_raster_p.

Test Plan:
1. Defaults, outline, r=10, centre (80,60), colour 3'b100:
   - One cycle after start, state=PREP.
   - Exactly 64 vga_plot pulses, including (90,60), (80,70), (73,53), (87,67).
   - vga_colour=4 throughout.
   - done rises.
2. Done handshake:
   - With start held, done stays 1 for 20+ cycles with vga_plot=0.
   - Drop start: done=0 next cycle and state=READY.
   - Re-assert start: a new draw begins.
3. Clipping, outline, r=10, centre (0,0):
   - 64 PLOT cycles.
   - Exactly 18 vga_plot pulses, all with x<160 and y<120.
   - Total cycle count equals scenario 1.
4. Fill, r=1, centre (10,10):
   - 20 plot pulses.
   - Unique pixel set is exactly the 9 pixels x,y in 9..11.
   - Fill r=0: 4 pulses at (10,10).
5. Reset mid-draw:
   - Drop rst_n asynchronously (between clock edges) during PLOT of scenario 1.
   - vga_plot, done, vga_x, vga_y, vga_colour go to 0 immediately.
   - After release, a fresh start completes normally.
6. Parameter override, X_W=9, Y_W=8, R_W=9, SCREEN_W=320, SCREEN_H=240, outline, r=200, centre (160,120):
   - No vga_plot with x>=320 or y>=240.
   - done asserts.
   - Plot count equals 8 times the iteration count from a reference model.
